mem_byte_responder: RTL
=======================

Name: mem_byte_responder

Overview:
- Memory-side responder for the CPU bus interface. Accepts byte or word read/write requests and serves them from a byte-wide memory, one byte access at a time.
- Word accesses always take two byte cycles, at addr and addr+1, so odd-aligned words need no clock inhibit on this side.
- Returns little-endian 16-bit read data with a one-cycle ack. Sign extension and lane swapping remain on the CPU side.

Parameters:
- ADDR_W, 16, address width of request and memory port.
- WAIT_CYCLES, 0, extra cycles mem_en is held per byte access (memory latency); range 0..15.

Ports:
- clk_no_inhibit  in  1  free-running clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  request valid; sampled only in IDLE.
- addr  in  ADDR_W  byte address of the access (low byte for words).
- word  in  1  1 = 16-bit access, 0 = 8-bit.
- we  in  1  1 = write, 0 = read.
- wdata  in  16  write data; [7:0] to addr, [15:8] to addr+1.
- rdata  out  16  read data; valid when ack=1, held until next read ack.
- ack  out  1  one-cycle completion pulse (reads and writes).
- busy  out  1  high in every state except IDLE.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  byte from memory.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write strobe, qualified by mem_en.

Behaviour:
- Reset (async, immediate): state=IDLE. ack, busy, mem_en, mem_we = 0. rdata, mem_addr, mem_wdata = 0. Wait counter = 0. An in-flight transaction is abandoned with no ack.
- States: IDLE, ACC_LO, ACC_HI, ACK.
- IDLE:
  - If req=1: latch addr, word, we, wdata, then go to ACC_LO with the counter cleared.
  - If req=0: stay in IDLE.
- ACC_LO:
  - Outputs: mem_en=1, mem_addr=latched addr, mem_we=latched we, mem_wdata=wdata[7:0].
  - Stays for WAIT_CYCLES+1 cycles.
  - On the last cycle, a read captures mem_rdata into the low byte of a temp register.
  - Next state: ACC_HI if word, else ACK.
- ACC_HI:
  - Same as ACC_LO, with mem_addr = latched addr + 1 (mod 2^ADDR_W, so 0xFFFF wraps to 0x0000) and mem_wdata = wdata[15:8].
  - A read captures mem_rdata into the high byte on the last cycle.
  - Next state: ACK.
- ACK:
  - ack=1 for exactly one cycle. mem_en=0.
  - On reads, rdata is loaded from the temp register. For byte reads, rdata[15:8]=0. On writes, rdata is unchanged.
  - Next state: IDLE. req is ignored during ACK, so a new request is accepted at the earliest one cycle after ack.
- Latency (req sampled at cycle 0):
  - Byte access: ack at cycle WAIT_CYCLES+2.
  - Word access: ack at cycle 2*WAIT_CYCLES+3.
  - With W=0: byte ack at cycle 2, word ack at cycle 3.
- Request changes: req deassertion or changes to addr/word/we/wdata after acceptance are ignored. The transaction completes and acks.
- Gaps: mem_en drops for no cycle between ACC_LO and ACC_HI. mem_addr changes on the cycle boundary.
- Byte write: exactly one mem_we cycle group; addr+1 is never touched.
- Write/read ordering: a read issued after a write's ack observes the written data.

Decomposition:
- Shared package mem_resp_pkg:
  - State enum (IDLE, ACC_LO, ACC_HI, ACK; 2-bit encoding).
  - Counter width constant, derived as 4 bits for the WAIT_CYCLES range.
  - Byte-lane index constants LO=0, HI=1.
- Sub-module access_timer:
  - Loadable down-counter.
  - Inputs: start, clk_no_inhibit, reset_n.
  - Output: last, asserted on the final cycle of a byte access.
  - Reused for both byte phases.

Test Plan:
- Byte read, W=0: memory[0x0010]=0xA5, req addr=0x0010 word=0 we=0 → mem_en high for 1 cycle with mem_addr=0x0010; ack at cycle 2; rdata=0x00A5.
- Odd word read, W=0: mem[0x0011]=0x34, mem[0x0012]=0x12, req addr=0x0011 word=1 → mem_addr 0x0011 then 0x0012; ack at cycle 3; rdata=0x1234.
- Word write with wrap, W=2: addr=0xFFFF wdata=0xBEEF → mem_we writes 0xEF at 0xFFFF (3 cycles) then 0xBE at 0x0000 (3 cycles); ack at cycle 7; rdata unchanged.
- Byte write: addr=0x0020 wdata=0x7788 → only 0x88 written at 0x0020; 0x0021 untouched; ack at cycle 2.
- Reset mid-operation: word read, W=3, reset_n driven low during ACC_HI → mem_en, busy, ack drop to 0 immediately, no ack pulse; after release, a new byte read completes normally.
- Back-to-back requests: req held high continuously with two byte reads → second request accepted the cycle after the first ack; ack pulses exactly one cycle each.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the byte-wide memory responder.
// Used by the top-level FSM and the per-byte access timer.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    ACK    = 2'd3
  } state_t;

  // Four bits cover the full 0..15 range of extra wait cycles.
  localparam int CNT_W = 4;

  localparam int LO = 0;
  localparam int HI = 1;

endpackage

// File: rtl/mem_byte_responder_if.sv
// CPU request/response bus plus the byte-wide memory port of the responder.
// The slave modport is the responder's view; master is the CPU/memory environment.
interface mem_byte_responder_if #(
  parameter int ADDR_W = 16
);

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              word;
  logic              we;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic              ack;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_en;
  logic              mem_we;

  modport slave (
    input  req, addr, word, we, wdata, mem_rdata,
    output rdata, ack, busy, mem_addr, mem_wdata, mem_en, mem_we
  );

  modport master (
    output req, addr, word, we, wdata, mem_rdata,
    input  rdata, ack, busy, mem_addr, mem_wdata, mem_en, mem_we
  );

endinterface

// File: rtl/access_timer.sv
// Loadable down-counter timing one byte access of WAIT_CYCLES+1 cycles.
// start loads the count on the cycle before a phase; last flags the phase's final cycle.
module access_timer
  import mem_resp_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk_no_inhibit,
  input  logic reset_n,
  input  logic start,
  output logic last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_no_inhibit or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(WAIT_CYCLES);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/mem_byte_responder.sv
// Memory-side responder: serves byte/word requests one byte access at a time
// from a byte-wide memory and returns little-endian 16-bit read data with a one-cycle ack.
module mem_byte_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input logic                 clk_no_inhibit,
  input logic                 reset_n,
  mem_byte_responder_if.slave bus
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic              word_q;
  logic              we_q;
  logic [15:0]       wdata_q;
  logic [7:0]        lo_q;
  logic [1:0][7:0]   rdata_q;
  logic              accept;
  logic              start;
  logic              last;

  access_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk_no_inhibit(clk_no_inhibit),
    .reset_n       (reset_n),
    .start         (start),
    .last          (last)
  );

  always_ff @(posedge clk_no_inhibit or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory strobes are decoded from the state so a reset drops them immediately.
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    start         = 1'b0;
    bus.ack       = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 8'h00;
    case (state)
      IDLE: begin
        if (bus.req) begin
          accept     = 1'b1;
          start      = 1'b1;
          state_next = ACC_LO;
        end
      end
      ACC_LO: begin
        bus.mem_en    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q[7:0];
        if (last) begin
          start      = word_q;
          state_next = word_q ? ACC_HI : ACK;
        end
      end
      ACC_HI: begin
        bus.mem_en    = 1'b1;
        bus.mem_addr  = addr_q + ADDR_W'(1);
        bus.mem_wdata = wdata_q[15:8];
        if (last) begin
          state_next = ACK;
        end
      end
      ACK: begin
        bus.ack    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    bus.mem_we = bus.mem_en & we_q;
    bus.busy   = (state != IDLE);
  end

  // rdata is loaded on the edge into ACK so it is already valid while ack is high.
  always_ff @(posedge clk_no_inhibit or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      word_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 16'h0000;
      lo_q    <= 8'h00;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.addr;
        word_q  <= bus.word;
        we_q    <= bus.we;
        wdata_q <= bus.wdata;
      end
      if (!we_q && last) begin
        if (state == ACC_LO) begin
          lo_q <= bus.mem_rdata;
          if (!word_q) begin
            rdata_q[HI] <= 8'h00;
            rdata_q[LO] <= bus.mem_rdata;
          end
        end else if (state == ACC_HI) begin
          rdata_q[HI] <= bus.mem_rdata;
          rdata_q[LO] <= lo_q;
        end
      end
    end
  end

  assign bus.rdata = rdata_q;

endmodule
